// File: rtl/cavlc_blk_sched_if.sv
// ---------------------------------------------------------------------------
// cavlc_blk_sched_if : macroblock request, coefficient read and CAVLC handoff
// bus. Optional CAVLC_SCHED_STALL_CNT_EN adds stall_cycles. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface cavlc_blk_sched_if #(
  parameter int COEF_W = 15,
  parameter int XY_W   = 10
);
  logic                   mb_start;
  logic [XY_W-5:0]        mb_x;
  logic [XY_W-5:0]        mb_y;
  logic                   mb_busy;
  logic                   mb_done;
  logic                   coef_rd_en;
  logic [3:0]             coef_rd_addr;
  logic [16*COEF_W-1:0]   coef_rd_data;
  logic                   cavlc_valid;
  logic                   cavlc_cnt_ready;
  logic [16*COEF_W-1:0]   cavlc_coef;
  logic [XY_W-1:0]        topleft_x;
  logic [XY_W-1:0]        topleft_y;
  logic                   cavlc_enc_valid;
`ifdef CAVLC_SCHED_STALL_CNT_EN
  logic [15:0]            stall_cycles;
`endif

  modport master (
    input  mb_start, mb_x, mb_y, coef_rd_data, cavlc_cnt_ready, cavlc_enc_valid,
`ifdef CAVLC_SCHED_STALL_CNT_EN
    output stall_cycles,
`endif
    output mb_busy, mb_done, coef_rd_en, coef_rd_addr, cavlc_valid, cavlc_coef,
           topleft_x, topleft_y
  );

  modport slave (
    output mb_start, mb_x, mb_y, coef_rd_data, cavlc_cnt_ready, cavlc_enc_valid,
`ifdef CAVLC_SCHED_STALL_CNT_EN
    input  stall_cycles,
`endif
    input  mb_busy, mb_done, coef_rd_en, coef_rd_addr, cavlc_valid, cavlc_coef,
           topleft_x, topleft_y
  );
endinterface

`default_nettype wire

// File: rtl/cavlc_blk_sched.sv
// ---------------------------------------------------------------------------
// cavlc_blk_sched : fetches the 16 luma 4x4 blocks of a macroblock in scan
// order and hands them to the CAVLC counter. Option: CAVLC_SCHED_STALL_CNT_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cavlc_blk_sched #(
  parameter int COEF_W = 15,
  parameter int XY_W   = 10
) (
  input  wire               clk_i,
  input  wire               rst_ni,
  cavlc_blk_sched_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic [3:0]           blk_idx_q, blk_idx_d;
  logic [4:0]           enc_cnt_q, enc_cnt_d;
  logic [XY_W-5:0]      mb_x_q, mb_x_d, mb_y_q, mb_y_d;
  logic [16*COEF_W-1:0] coef_q, coef_d;
  logic [XY_W-1:0]      tlx_q, tlx_d, tly_q, tly_d;
  logic                 enc_counting;

  assign enc_counting = (state_q == S_READ) || (state_q == S_WAIT) ||
                        (state_q == S_ISSUE) || (state_q == S_DRAIN);

  always_comb begin
    state_d   = state_q;
    blk_idx_d = blk_idx_q;
    mb_x_d    = mb_x_q;
    mb_y_d    = mb_y_q;
    coef_d    = coef_q;
    tlx_d     = tlx_q;
    tly_d     = tly_q;
    enc_cnt_d = enc_cnt_q;
    if (enc_counting && bus.cavlc_enc_valid && (enc_cnt_q != 5'd16))
      enc_cnt_d = enc_cnt_q + 5'd1;

    case (state_q)
      S_IDLE: begin
        if (bus.mb_start) begin
          mb_x_d    = bus.mb_x;
          mb_y_d    = bus.mb_y;
          blk_idx_d = 4'd0;
          enc_cnt_d = 5'd0;
          state_d   = S_READ;
        end
      end
      S_READ:  state_d = S_WAIT;
      S_WAIT: begin
        // Scan order: bit0/bit2 select the 4/8 pixel x step, bit1/bit3 the y step.
        coef_d  = bus.coef_rd_data;
        tlx_d   = {mb_x_q, 4'b0000} +
                  {{(XY_W-4){1'b0}}, blk_idx_q[2], blk_idx_q[0], 2'b00};
        tly_d   = {mb_y_q, 4'b0000} +
                  {{(XY_W-4){1'b0}}, blk_idx_q[3], blk_idx_q[1], 2'b00};
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (bus.cavlc_cnt_ready) begin
          if (blk_idx_q == 4'd15) begin
            state_d = S_DRAIN;
          end else begin
            blk_idx_d = blk_idx_q + 4'd1;
            state_d   = S_READ;
          end
        end
      end
      S_DRAIN: if (enc_cnt_d == 5'd16) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      blk_idx_q <= 4'd0;
      enc_cnt_q <= 5'd0;
      mb_x_q    <= '0;
      mb_y_q    <= '0;
      coef_q    <= '0;
      tlx_q     <= '0;
      tly_q     <= '0;
    end else begin
      state_q   <= state_d;
      blk_idx_q <= blk_idx_d;
      enc_cnt_q <= enc_cnt_d;
      mb_x_q    <= mb_x_d;
      mb_y_q    <= mb_y_d;
      coef_q    <= coef_d;
      tlx_q     <= tlx_d;
      tly_q     <= tly_d;
    end
  end

  assign bus.mb_busy      = (state_q != S_IDLE);
  assign bus.mb_done      = (state_q == S_DONE);
  assign bus.coef_rd_en   = (state_q == S_READ);
  assign bus.coef_rd_addr = (state_q == S_READ) ? blk_idx_q : 4'd0;
  assign bus.cavlc_valid  = (state_q == S_ISSUE);
  assign bus.cavlc_coef   = coef_q;
  assign bus.topleft_x    = tlx_q;
  assign bus.topleft_y    = tly_q;

`ifdef CAVLC_SCHED_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == S_IDLE) && bus.mb_start)
      stall_d = 16'd0;
    else if ((state_q == S_ISSUE) && !bus.cavlc_cnt_ready && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stall_q <= 16'd0;
    else         stall_q <= stall_d;
  end

  assign bus.stall_cycles = stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cavlc_blk_sched.sv
// ---------------------------------------------------------------------------
// tb_cavlc_blk_sched : scoreboard bench for cavlc_blk_sched with a block-scan
// reference model and decoupled monitor. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cavlc_blk_sched;
  localparam int COEF_W = 15;
  localparam int XY_W   = 10;
  localparam int CW     = 16 * COEF_W;

  typedef struct {
    logic [CW-1:0]   coef;
    logic [XY_W-1:0] x;
    logic [XY_W-1:0] y;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cavlc_blk_sched_if #(.COEF_W(COEF_W), .XY_W(XY_W)) bus ();
  cavlc_blk_sched #(.COEF_W(COEF_W), .XY_W(XY_W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int n_chk = 0, n_fail = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [CW-1:0] mem [16];
  exp_t exq[$];
  exp_t e;
  int   encq[$];
  int   enc_last = 0;
  bit   active = 0;
  int   S = 0, acc = 0, enc_seen = 0, A = -1, P = -1, D = -1, done_at = -1;
  int   exp_addr = 0, stall_m = 0, done_cnt = 0, stall_left = 0;
  int   ready_mode = 0, enc_mode = 0;
  bit   prev_stall = 0;
  logic [CW-1:0]   snap_coef;
  logic [XY_W-1:0] snap_x, snap_y;
  logic            d_p;
  logic [3:0]      d_a;

  task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic logic [CW-1:0] rand_blk();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r[CW-1:0];
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Coefficient buffer: data valid only in the cycle after a read strobe.
  initial forever begin
    @(negedge clk);
    d_p = bus.coef_rd_en;
    d_a = bus.coef_rd_addr;
    @(posedge clk);
    #1;
    bus.coef_rd_data = d_p ? mem[d_a] : rand_blk();
  end

  // Ready and encoder-completion drivers.
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0: bus.cavlc_cnt_ready = 1'b1;
      1: bus.cavlc_cnt_ready = ($urandom % 3) != 0;
      2: bus.cavlc_cnt_ready = !(acc == 3 && stall_left > 0);
      default: bus.cavlc_cnt_ready = (acc != 7);
    endcase
    if (enc_mode == 0 || enc_mode == 2) begin
      if (encq.size() > 0 && encq[0] <= cyc) begin
        bus.cavlc_enc_valid = 1'b1;
        void'(encq.pop_front());
      end else begin
        bus.cavlc_enc_valid = 1'b0;
      end
    end else if (enc_mode == 3) begin
      bus.cavlc_enc_valid = $urandom % 2;
    end
  end

  // Monitor / scoreboard.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (bus.mb_start && !active) begin
        active = 1; S = cyc; acc = 0; enc_seen = 0; A = -1; P = -1; D = -1;
        exp_addr = 0; stall_m = 0; prev_stall = 0;
        exq.delete();
        for (int b = 0; b < 16; b++) begin
          e.coef = mem[b];
          e.x = XY_W'(int'(bus.mb_x) * 16 + 4 * (b % 2) + 8 * ((b / 4) % 2));
          e.y = XY_W'(int'(bus.mb_y) * 16 + 4 * ((b / 2) % 2) + 8 * (b / 8));
          exq.push_back(e);
        end
      end
      chk("mb_busy", bus.mb_busy, active && cyc > S);
      if (bus.coef_rd_en) begin
        chk("coef_rd_addr", bus.coef_rd_addr, active ? exp_addr : 16);
        exp_addr++;
      end
      if (prev_stall) begin
        chk("valid_hold", bus.cavlc_valid, 1);
        chk("coef_hold", bus.cavlc_coef, snap_coef);
        chk("topleft_x_hold", bus.topleft_x, snap_x);
        chk("topleft_y_hold", bus.topleft_y, snap_y);
      end
      prev_stall = 0;
      if (bus.cavlc_valid) begin
        if (!active || exq.size() == 0) begin
          chk("valid_unexpected", 1, 0);
        end else if (bus.cavlc_cnt_ready) begin
          e = exq.pop_front();
          chk("cavlc_coef", bus.cavlc_coef, e.coef);
          chk("topleft_x", bus.topleft_x, e.x);
          chk("topleft_y", bus.topleft_y, e.y);
          acc++;
          if (acc == 16) A = cyc;
          if (enc_mode == 0) begin
            enc_last = (cyc + 2 > enc_last + 1) ? cyc + 2 : enc_last + 1;
            encq.push_back(enc_last);
          end else if (enc_mode == 2) begin
            enc_last = (cyc + $urandom_range(1, 6) > enc_last + 1) ?
                       cyc + $urandom_range(1, 6) : enc_last + 1;
            encq.push_back(enc_last);
          end
        end else begin
          stall_m++;
          if (ready_mode == 2 && stall_left > 0) stall_left--;
          prev_stall = 1;
          snap_coef = bus.cavlc_coef;
          snap_x = bus.topleft_x;
          snap_y = bus.topleft_y;
        end
      end
      if (bus.cavlc_enc_valid && active && cyc > S) begin
        enc_seen++;
        if (enc_seen == 16) P = cyc;
      end
      if (A >= 0 && P >= 0) D = ((A + 1 > P) ? A + 1 : P) + 1;
      if (bus.mb_done) begin
        if (!active || D < 0) begin
          chk("mb_done_unexpected", 1, 0);
        end else begin
          chk("mb_done_cycle", cyc, D);
`ifdef CAVLC_SCHED_STALL_CNT_EN
          chk("stall_cycles", bus.stall_cycles, stall_m);
`endif
        end
        done_at = cyc;
        done_cnt++;
        active = 0;
      end else if (active && D >= 0 && cyc == D) begin
        chk("mb_done_missing", 0, 1);
      end
    end
  end

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    while (active && n < lim) begin step(1); n++; end
    if (active) begin chk("timeout_idle", 0, 1); active = 0; end
  endtask

  task automatic start_mb(input int x, input int y);
    for (int b = 0; b < 16; b++) mem[b] = rand_blk();
    bus.mb_x = (XY_W-4)'(x);
    bus.mb_y = (XY_W-4)'(y);
    bus.mb_start = 1'b1;
    step(1);
    bus.mb_start = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_mb_busy"}, bus.mb_busy, 0);
    chk({tag, "_mb_done"}, bus.mb_done, 0);
    chk({tag, "_coef_rd_en"}, bus.coef_rd_en, 0);
    chk({tag, "_coef_rd_addr"}, bus.coef_rd_addr, 0);
    chk({tag, "_cavlc_valid"}, bus.cavlc_valid, 0);
    chk({tag, "_cavlc_coef"}, bus.cavlc_coef, 0);
    chk({tag, "_topleft_x"}, bus.topleft_x, 0);
    chk({tag, "_topleft_y"}, bus.topleft_y, 0);
`ifdef CAVLC_SCHED_STALL_CNT_EN
    chk({tag, "_stall_cycles"}, bus.stall_cycles, 0);
`endif
  endtask

  int d0, n;

  initial begin
    bus.mb_start = 1'b0; bus.mb_x = '0; bus.mb_y = '0;
    bus.coef_rd_data = '0; bus.cavlc_cnt_ready = 1'b0; bus.cavlc_enc_valid = 1'b0;
    ready_mode = 0; enc_mode = 1;
    step(3);
    chk_outputs_zero("reset");
    rst_n = 1'b1;

    // Idle with encoder pulses toggling: nothing may start.
    enc_mode = 3;
    step(20);
    enc_mode = 0;
    bus.cavlc_enc_valid = 1'b0;
    chk("idle_mb_busy", bus.mb_busy, 0);

    // Nominal macroblock, ready always high, encoder 2 cycles behind.
    d0 = done_cnt;
    start_mb(2, 1);
    wait_idle(200);
    chk("nominal_last_accept_latency", A - S, 48);
    chk("nominal_done_once", done_cnt - d0, 1);

    // Back-pressure of 5 cycles on block 3.
    ready_mode = 2; stall_left = 5;
    start_mb($urandom_range(0, 63), $urandom_range(0, 63));
    wait_idle(200);
`ifdef CAVLC_SCHED_STALL_CNT_EN
    chk("stall_cycles_block3", bus.stall_cycles, 5);
`endif
    ready_mode = 0;

    // Encoder lag: all completions after the final accept.
    enc_mode = 1;
    start_mb(63, 63);
    n = 0;
    while (acc < 16 && n < 200) begin step(1); n++; end
    step(4);
    chk("lag_still_busy", bus.mb_busy, 1);
    for (int i = 0; i < 16; i++) begin
      bus.cavlc_enc_valid = 1'b1;
      step(1);
      bus.cavlc_enc_valid = 1'b0;
      step($urandom_range(0, 2));
    end
    wait_idle(50);
    chk("lag_done_after_last_pulse", done_at - P, 1);
    enc_mode = 0;

    // mb_start while busy is ignored; next start begins at block 0.
    d0 = done_cnt;
    start_mb(3, 4);
    step(10);
    bus.mb_x = 6'd9; bus.mb_start = 1'b1;
    step(1);
    bus.mb_start = 1'b0;
    wait_idle(200);
    start_mb(5, 6);
    wait_idle(200);
    chk("busy_start_ignored", done_cnt - d0, 2);

    // Asynchronous reset while block 7 waits in ISSUE.
    ready_mode = 3;
    d0 = done_cnt;
    start_mb(7, 2);
    n = 0;
    do begin @(negedge clk); n++; end while (!(bus.cavlc_valid && acc == 7) && n < 200);
    if (n >= 200) chk("timeout_block7", 0, 1);
    #2 rst_n = 1'b0;
    #1 chk_outputs_zero("abort");
    active = 0; prev_stall = 0; exq.delete(); encq.delete();
    step(2);
    chk("abort_no_done", done_cnt - d0, 0);
    rst_n = 1'b1;
    ready_mode = 0;
    start_mb(1, 1);
    wait_idle(200);
    chk("restart_done", done_cnt - d0, 1);

    // Randomized macroblocks with random back-pressure and encoder delay.
    ready_mode = 1; enc_mode = 2;
    d0 = done_cnt;
    for (int k = 0; k < 6; k++) begin
      start_mb($urandom_range(0, 63), $urandom_range(0, 63));
      wait_idle(600);
      step($urandom_range(0, 3));
    end
    chk("random_done_count", done_cnt - d0, 6);
    chk("scoreboard_empty", exq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cavlc_blk_sched.md
# cavlc_blk_sched

Macroblock-level scheduler in front of the CAVLC count/encode pipeline. On a macroblock start request it fetches the sixteen 4x4 luma coefficient blocks from the coefficient buffer in H.264 block-scan order and presents each one to the CAVLC counter with its pixel top-left coordinate, under a valid/ready handshake. It counts encoder completions and signals macroblock done once all sixteen blocks are both issued and encoded.

## Interface
Parameters:
- COEF_W, 15: width of one quantized coefficient.
- XY_W, 10: width of pixel coordinates.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- mb_start  in  1  start-of-macroblock request; sampled only in IDLE.
- mb_x  in  XY_W-4  macroblock column index, sampled with mb_start.
- mb_y  in  XY_W-4  macroblock row index, sampled with mb_start.
- mb_busy  out  1  high from the cycle after an accepted mb_start through the mb_done cycle.
- mb_done  out  1  one-cycle pulse; macroblock fully encoded.
- coef_rd_en  out  1  coefficient buffer read strobe.
- coef_rd_addr  out  4  block index 0..15 within the macroblock.
- coef_rd_data  in  16*COEF_W  coefficients of the addressed block, valid exactly 1 cycle after coef_rd_en; raster order, coef [i*4+j] at bits [(i*4+j)*COEF_W +: COEF_W] (scale_ij).
- cavlc_valid  out  1  block presented to the CAVLC counter.
- cavlc_cnt_ready  in  1  CAVLC counter accepts; transfer occurs when valid && ready.
- cavlc_coef  out  16*COEF_W  captured block, same packing as coef_rd_data.
- topleft_x  out  XY_W  pixel x of the presented block.
- topleft_y  out  XY_W  pixel y of the presented block.
- cavlc_enc_valid  in  1  one-cycle pulse per block finished by the encoder.

## Operation
- States: IDLE, READ, WAIT, ISSUE, DRAIN, DONE.
- IDLE: on mb_start, latch mb_x/mb_y, clear blk_idx (4b) and enc_cnt (5b), go to READ.
- READ (1 cycle): coef_rd_en=1, coef_rd_addr=blk_idx; go to WAIT.
- WAIT (1 cycle): capture coef_rd_data into cavlc_coef; compute topleft; go to ISSUE.
- ISSUE: cavlc_valid=1; cavlc_coef, topleft_x/y held stable until accepted. On acceptance: if blk_idx==15 go to DRAIN, else blk_idx+1 and go to READ.
- DRAIN: wait until enc_cnt==16, then go to DONE.
- DONE (1 cycle): mb_done=1; go to IDLE.
- Block order b -> offset: x_off = 8*b[2] + 4*b[0], y_off = 8*b[3] + 4*b[1]. topleft_x = {mb_x,4'b0} + x_off; topleft_y = {mb_y,4'b0} + y_off. No carry beyond XY_W bits; the result wraps modulo 2^XY_W.
- enc_cnt increments on every cavlc_enc_valid in READ/WAIT/ISSUE/DRAIN and saturates at 16. Pulses in IDLE/DONE are ignored.
- mb_start outside IDLE is ignored, with no queueing.

## Timing
- Reset values: all outputs 0, state IDLE, blk_idx 0, enc_cnt 0.
- With mb_start at cycle 0: coef_rd_en at cycle 1, capture at cycle 2, cavlc_valid at cycle 3.
- With ready constantly high, each block takes 3 cycles, and block 15 is accepted at cycle 48.
- mb_done is asserted the cycle after enc_cnt reaches 16 while in DRAIN, or the cycle after entering DRAIN if the count is already 16.
- cavlc_enc_valid coinciding with the final ISSUE acceptance is counted.
- Reset asserted mid-macroblock: all state and outputs return to reset values asynchronously. No mb_done is generated for the aborted macroblock.

## Configuration
- CAVLC_SCHED_STALL_CNT_EN defined: adds output port stall_cycles (16 bits).
  - Counts cycles with cavlc_valid=1 and cavlc_cnt_ready=0.
  - Cleared when mb_start is accepted; saturates at 16'hFFFF; holds its value after mb_done; reset value 0.
- CAVLC_SCHED_STALL_CNT_EN undefined: the port and the counter do not exist.

## Test plan
- Reset then idle: all outputs 0; mb_busy stays 0 for 20 cycles with cavlc_enc_valid toggling.
- mb_x=2, mb_y=1, ready always 1, encoder pulses 2 cycles after each accept:
  - topleft sequence (32,16),(36,16),(32,20),(36,20),(40,16)… ends at (44,28);
  - coef_rd_addr runs 0..15; mb_done fires exactly once.
- Ready held 0 for 5 cycles on block 3: cavlc_valid, cavlc_coef and topleft remain stable; stall_cycles=5 with the macro defined.
- Encoder lag, with all 16 enc pulses arriving after the last accept: FSM stays in DRAIN; mb_done occurs 1 cycle after the 16th pulse.
- mb_start pulsed while busy: ignored; the macroblock ends normally; a new mb_start in IDLE begins at block 0.
- rst asserted while in ISSUE on block 7: outputs 0 immediately; after release, a fresh mb_start restarts cleanly at block 0.
